// File: rtl/bullet_pkg.sv
// Shared types and helpers for the bullet pool: slot state, allocation result,
// screen constants and the lowest-free-slot search.
package bullet_pkg;
  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int MAX_SLOTS = 16;

  typedef struct packed {
    logic       active;
    logic [9:0] x;
    logic [9:0] y;
  } bullet_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } alloc_t;

  // Pad unused upper bits of the mask with 1s so they never look free.
  function automatic alloc_t first_free(input logic [MAX_SLOTS-1:0] mask);
    alloc_t r;
    r = '0;
    for (int i = MAX_SLOTS-1; i >= 0; i--)
      if (!mask[i]) begin
        r.valid = 1'b1;
        r.idx   = 4'(i);
      end
    return r;
  endfunction
endpackage

// File: rtl/bullet_slot.sv
// One projectile slot: clear > spawn > move priority, plus its own pixel cover.
module bullet_slot #(
  parameter int SPEED    = 4,
  parameter int DIR_UP   = 1,
  parameter int SPAWN_Y  = 440,
  parameter int BW       = 2,
  parameter int BH       = 8,
  parameter int SCREEN_H = 480
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       spawn_i,
  input  logic       tick_i,
  input  logic [9:0] spawn_x_i,
  input  logic [9:0] draw_x_i,
  input  logic [9:0] draw_y_i,
  output logic       active_o,
  output logic       cover_o
);
  import bullet_pkg::*;

  bullet_t     st_q, st_d;
  logic [10:0] x_ext, y_ext, y_dn, dx, dy;

  assign x_ext = {1'b0, st_q.x};
  assign y_ext = {1'b0, st_q.y};
  assign y_dn  = y_ext + 11'(SPEED);
  assign dx    = {1'b0, draw_x_i};
  assign dy    = {1'b0, draw_y_i};

  always_comb begin
    st_d = st_q;
    if (clr_i) begin
      st_d.active = 1'b0;
    end else if (spawn_i) begin
      st_d.active = 1'b1;
      st_d.x      = spawn_x_i;
      st_d.y      = 10'(SPAWN_Y);
    end else if (tick_i && st_q.active) begin
      // Leaving the screen retires the slot instead of wrapping.
      if (DIR_UP != 0) begin
        if (y_ext < 11'(SPEED)) st_d.active = 1'b0;
        else                    st_d.y      = st_q.y - 10'(SPEED);
      end else begin
        if (y_dn >= 11'(SCREEN_H)) st_d.active = 1'b0;
        else                       st_d.y      = y_dn[9:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) st_q <= '0;
    else         st_q <= st_d;

  assign active_o = st_q.active;
  assign cover_o  = st_q.active && (dx >= x_ext) && (dx < x_ext + 11'(BW))
                                && (dy >= y_ext) && (dy < y_ext + 11'(BH));
endmodule

// File: rtl/bullet_pool.sv
// Multi-projectile manager: fire allocator with cooldown, frame-tick motion,
// hit clearing and per-pixel coverage reduction over NUM_BULLETS slots.
module bullet_pool #(
  parameter int NUM_BULLETS = 4,
  parameter int SPEED       = 4,
  parameter int DIR_UP      = 1,
  parameter int COOLDOWN    = 8,
  parameter int SPAWN_Y     = 440,
  parameter int X_OFFSET    = 12,
  parameter int BW          = 2,
  parameter int BH          = 8,
  parameter int SCREEN_H    = 480
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   frame_clk,
  input  logic                   enable,
  input  logic                   fire,
  input  logic [9:0]             spawn_x,
  input  logic                   hit_valid,
  input  logic [3:0]             hit_idx,
  input  logic [9:0]             DrawX,
  input  logic [9:0]             DrawY,
  output logic                   bullet_on,
  output logic [3:0]             bullet_idx,
  output logic [NUM_BULLETS-1:0] active_mask,
  output logic [4:0]             active_count,
  output logic                   fire_ack,
  output logic                   fire_drop
);
  import bullet_pkg::*;

  localparam int CDW = $clog2(COOLDOWN + 2);

  logic                   fs1_q, fs2_q, frame_prev_q, fire_prev_q;
  logic                   ack_q, drop_q;
  logic [CDW-1:0]         cd_q, cd_d;
  logic                   tick, fire_edge, armed, accept, reject;
  logic [NUM_BULLETS-1:0] act, cov, clr, spawn;
  logic [MAX_SLOTS-1:0]   mask_ext;
  logic [9:0]             sx;
  alloc_t                 ff;

  assign tick      = fs2_q & ~frame_prev_q;
  assign fire_edge = fire & ~fire_prev_q;
  assign sx        = spawn_x + 10'(X_OFFSET);

  always_comb begin
    mask_ext                = '1;
    mask_ext[NUM_BULLETS-1:0] = act;
  end

  // Allocation uses the pre-hit mask, so a slot freed this cycle waits a cycle.
  assign ff     = first_free(mask_ext);
  assign armed  = fire_edge & enable & (cd_q == '0);
  assign accept = armed & ff.valid;
  assign reject = armed & ~ff.valid;

  for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_slot
    assign clr[i]   = ~enable | (hit_valid & (hit_idx == 4'(i)) & act[i]);
    assign spawn[i] = accept & (ff.idx == 4'(i));

    bullet_slot #(
      .SPEED(SPEED), .DIR_UP(DIR_UP), .SPAWN_Y(SPAWN_Y),
      .BW(BW), .BH(BH), .SCREEN_H(SCREEN_H)
    ) u_slot (
      .clk_i(Clk), .rst_ni(Reset_n), .clr_i(clr[i]), .spawn_i(spawn[i]),
      .tick_i(tick), .spawn_x_i(sx), .draw_x_i(DrawX), .draw_y_i(DrawY),
      .active_o(act[i]), .cover_o(cov[i])
    );
  end

  always_comb begin
    cd_d = cd_q;
    if (!enable)                  cd_d = '0;
    else if (accept)              cd_d = CDW'(COOLDOWN);
    else if (tick && cd_q != '0)  cd_d = cd_q - 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      fs1_q        <= 1'b0;
      fs2_q        <= 1'b0;
      frame_prev_q <= 1'b0;
      fire_prev_q  <= 1'b0;
      cd_q         <= '0;
      ack_q        <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      fs1_q        <= frame_clk;
      fs2_q        <= fs1_q;
      frame_prev_q <= fs2_q;
      fire_prev_q  <= fire;
      cd_q         <= cd_d;
      ack_q        <= accept;
      drop_q       <= reject;
    end

  always_comb begin
    active_count = '0;
    bullet_idx   = '0;
    for (int i = 0; i < NUM_BULLETS; i++) active_count = active_count + 5'(act[i]);
    for (int i = NUM_BULLETS-1; i >= 0; i--) if (cov[i]) bullet_idx = 4'(i);
  end

  assign bullet_on   = |cov;
  assign active_mask = act;
  assign fire_ack    = ack_q;
  assign fire_drop   = drop_q;
endmodule

// File: tb/tb_bullet_pool.sv
// Directed bench over three pool instances (default, no-cooldown, downward);
// expectations are queued as stimulus is applied and checked when outputs settle.
module tb_bullet_pool;
  localparam int F_ON = 0, F_IDX = 1, F_MASK = 2, F_CNT = 3, F_ACK = 4, F_DROP = 5;

  logic Clk = 1'b0, Reset_n = 1'b0, frame_clk = 1'b0, enable = 1'b1;
  logic [2:0] fire_v = '0, hv = '0;
  logic [9:0] spawn_x = '0, DrawX = '0, DrawY = '0;
  logic [3:0] hit_idx = '0;
  logic [2:0] on_v, ack_v, drop_v;
  logic [2:0][3:0] idx_v, mask_v;
  logic [2:0][4:0] cnt_v;
  int tests = 0, fails = 0;

  typedef struct { string tag; int inst; int fld; int exp; } sb_t;
  sb_t sbq[$];

  always #5 Clk = ~Clk;

  bullet_pool u_a (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .enable(enable),
    .fire(fire_v[0]), .spawn_x(spawn_x), .hit_valid(hv[0]), .hit_idx(hit_idx),
    .DrawX(DrawX), .DrawY(DrawY), .bullet_on(on_v[0]), .bullet_idx(idx_v[0]),
    .active_mask(mask_v[0]), .active_count(cnt_v[0]), .fire_ack(ack_v[0]), .fire_drop(drop_v[0]));

  bullet_pool #(.COOLDOWN(0), .SPAWN_Y(10)) u_b (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .enable(enable),
    .fire(fire_v[1]), .spawn_x(spawn_x), .hit_valid(hv[1]), .hit_idx(hit_idx),
    .DrawX(DrawX), .DrawY(DrawY), .bullet_on(on_v[1]), .bullet_idx(idx_v[1]),
    .active_mask(mask_v[1]), .active_count(cnt_v[1]), .fire_ack(ack_v[1]), .fire_drop(drop_v[1]));

  bullet_pool #(.COOLDOWN(0), .DIR_UP(0), .SPEED(2), .SPAWN_Y(300)) u_c (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .enable(enable),
    .fire(fire_v[2]), .spawn_x(spawn_x), .hit_valid(hv[2]), .hit_idx(hit_idx),
    .DrawX(DrawX), .DrawY(DrawY), .bullet_on(on_v[2]), .bullet_idx(idx_v[2]),
    .active_mask(mask_v[2]), .active_count(cnt_v[2]), .fire_ack(ack_v[2]), .fire_drop(drop_v[2]));

  function automatic logic [15:0] probe(int inst, int fld);
    case (fld)
      F_ON:    return 16'(on_v[inst]);
      F_IDX:   return 16'(idx_v[inst]);
      F_MASK:  return 16'(mask_v[inst]);
      F_CNT:   return 16'(cnt_v[inst]);
      F_ACK:   return 16'(ack_v[inst]);
      default: return 16'(drop_v[inst]);
    endcase
  endfunction

  task automatic ex(string tag, int inst, int fld, int e);
    sbq.push_back('{tag, inst, fld, e});
  endtask

  task automatic drain();
    sb_t e;
    logic [15:0] o;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      o = probe(e.inst, e.fld);
      tests++;
      assert (o === 16'(e.exp)) else begin
        fails++;
        $error("FAIL %s inst%0d fld%0d got=%0h want=%0h", e.tag, e.inst, e.fld, o, e.exp);
      end
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Full frame: tick fires two cycles after frame_clk rises, motion lands on the third.
  task automatic frames(int n);
    repeat (n) begin
      frame_clk = 1'b1; step(3);
      frame_clk = 1'b0; step(2);
    end
  endtask

  task automatic fire_chk(string tag, int inst, int sx, int ack, int drop, int mask);
    ex(tag, inst, F_ACK, ack); ex(tag, inst, F_DROP, drop); ex(tag, inst, F_MASK, mask);
    spawn_x = 10'(sx); fire_v[inst] = 1'b1; step(1); drain();
    fire_v[inst] = 1'b0;
    ex({tag, "_pulse"}, inst, F_ACK, 0); ex({tag, "_pulse"}, inst, F_DROP, 0);
    step(1); drain();
  endtask

  task automatic pix(string tag, int inst, int x, int y, int on, int idx);
    DrawX = 10'(x); DrawY = 10'(y);
    ex(tag, inst, F_ON, on); ex(tag, inst, F_IDX, idx);
    @(negedge Clk); drain();
  endtask

  initial begin
    step(3);
    for (int i = 0; i < 3; i++) for (int f = 0; f < 6; f++) ex("reset", i, f, 0);
    drain();
    Reset_n = 1'b1; step(1);

    // Single shot, position and motion
    fire_chk("a_fire0", 0, 100, 1, 0, 1);
    ex("a_cnt1", 0, F_CNT, 1); drain();
    pix("a_spawn", 0, 112, 440, 1, 0);
    pix("a_br", 0, 113, 447, 1, 0);
    pix("a_right", 0, 114, 440, 0, 0);
    pix("a_left", 0, 111, 440, 0, 0);
    pix("a_below", 0, 112, 448, 0, 0);
    frames(3);
    pix("a_mv_top", 0, 112, 428, 1, 0);
    pix("a_mv_above", 0, 112, 427, 0, 0);
    pix("a_mv_bot", 0, 112, 436, 0, 0);

    // Cooldown: ignored after 3 frames, accepted after 8
    fire_chk("a_cd_ign", 0, 100, 0, 0, 1);
    frames(5);
    fire_chk("a_cd_ok", 0, 100, 1, 0, 3);
    ex("a_cnt2", 0, F_CNT, 2); drain();
    pix("a_s1", 0, 112, 440, 1, 1);
    pix("a_s0", 0, 112, 408, 1, 0);

    // Fill, overflow, hits
    for (int k = 0; k < 4; k++) fire_chk("b_fill", 1, k * 50, 1, 0, (1 << (k + 1)) - 1);
    fire_chk("b_full", 1, 200, 0, 1, 15);
    hv[1] = 1'b1; hit_idx = 4'd7; ex("b_hit_oor", 1, F_MASK, 15);
    step(1); drain(); hv[1] = 1'b0;
    hv[1] = 1'b1; hit_idx = 4'd2; fire_v[1] = 1'b1;
    ex("b_hitfire", 1, F_DROP, 1); ex("b_hitfire", 1, F_ACK, 0); ex("b_hitfire", 1, F_MASK, 11);
    step(1); drain(); hv[1] = 1'b0; fire_v[1] = 1'b0; step(1);
    frame_clk = 1'b1; step(2);
    hv[1] = 1'b1; hit_idx = 4'd1;
    ex("b_hittick", 1, F_MASK, 9); ex("b_hittick", 1, F_CNT, 2);
    step(1); drain(); hv[1] = 1'b0;
    frame_clk = 1'b0; step(2);
    pix("b_s0_mv", 1, 12, 6, 1, 0);
    pix("b_s0_above", 1, 12, 5, 0, 0);
    pix("b_s1_gone", 1, 62, 6, 0, 0);
    pix("b_s3_top", 1, 162, 6, 1, 3);
    pix("b_s3_bot", 1, 162, 13, 1, 3);
    pix("b_s3_past", 1, 162, 14, 0, 0);
    fire_chk("b_refill", 1, 300, 1, 0, 11);
    pix("b_s1_new", 1, 312, 10, 1, 1);
    pix("b_s2_gone", 1, 112, 10, 0, 0);

    // Top-edge exit without wrap
    frames(1);
    ex("b_y2", 1, F_MASK, 11); drain();
    pix("b_s0_y2", 1, 12, 2, 1, 0);
    frames(1);
    ex("b_exit", 1, F_MASK, 2); ex("b_exit", 1, F_CNT, 1); drain();
    pix("b_nowrap", 1, 12, 1022, 0, 0);
    pix("b_s1_y2", 1, 312, 2, 1, 1);
    frames(1);
    ex("b_empty", 1, F_MASK, 0); ex("b_empty", 1, F_CNT, 0); drain();

    // Downward instance: box edges and bottom exit
    fire_chk("c_fire", 2, 188, 1, 0, 1);
    pix("c_in", 2, 201, 307, 1, 0);
    pix("c_below", 2, 201, 308, 0, 0);
    pix("c_left", 2, 199, 300, 0, 0);
    pix("c_right", 2, 202, 300, 0, 0);
    pix("c_corner", 2, 200, 300, 1, 0);
    frames(89);
    pix("c_y478", 2, 200, 478, 1, 0);
    pix("c_y477", 2, 200, 477, 0, 0);
    frames(1);
    ex("c_exit", 2, F_MASK, 0); ex("a_alive", 0, F_MASK, 3); drain();

    // enable low clears slots and cooldown; fire edges neither acked nor dropped
    fire_chk("a_slot2", 0, 400, 1, 0, 7);
    enable = 1'b0;
    fire_chk("a_dis", 0, 400, 0, 0, 0);
    enable = 1'b1;
    fire_chk("a_reen", 0, 400, 1, 0, 1);

    // Asynchronous reset mid-cycle
    Reset_n = 1'b0; #2;
    ex("a_async", 0, F_MASK, 0); ex("a_async", 0, F_CNT, 0); drain();
    Reset_n = 1'b1; step(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bullet_pool.md
Name: bullet_pool

Overview:
- Parametrised multi-projectile manager; successor to the single-bullet block.
- Holds NUM_BULLETS independent bullet slots with:
  - fire handshake and per-frame cooldown
  - per-frame motion in a configurable direction
  - hit-driven clearing
  - a per-pixel query for color_mapper.
- One instance serves the player's shots (DIR_UP=1); further instances serve enemy shots (DIR_UP=0).
- Sits between player/enemy_array (spawn X, hit reports) and color_mapper (pixel coverage).

Parameters:
- NUM_BULLETS, 4: number of slots, 1..16.
- SPEED, 4: pixels moved per frame.
- DIR_UP, 1: 1 = Y decreases each frame; 0 = Y increases each frame.
- COOLDOWN, 8: minimum frames between accepted fires; 0 disables the cooldown.
- SPAWN_Y, 440: initial Y of a new bullet.
- X_OFFSET, 12: added to spawn_x at spawn.
- BW, 2: bullet width in pixels.
- BH, 8: bullet height in pixels.
- SCREEN_H, 480: exit boundary for DIR_UP=0.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous active-low reset.
- frame_clk  in  1  vertical sync; sampled in Clk and rising-edge detected internally.
- enable  in  1  game is_playing; low clears all slots.
- fire  in  1  level fire request from keycode decode.
- spawn_x  in  10  shooter X position.
- hit_valid  in  1  one-cycle hit report.
- hit_idx  in  4  slot index hit.
- DrawX  in  10  current pixel X.
- DrawY  in  10  current pixel Y.
- bullet_on  out  1  pixel covered by an active bullet.
- bullet_idx  out  4  lowest covering slot index.
- active_mask  out  NUM_BULLETS  per-slot active flags.
- active_count  out  5  number of active slots.
- fire_ack  out  1  one-cycle pulse: fire accepted.
- fire_drop  out  1  one-cycle pulse: fire rejected because the pool is full.

Behaviour:
- Reset values:
  - All slots inactive; x=0, y=0.
  - cooldown_cnt=0; fire_prev=0; frame_prev=0.
  - All outputs 0.
- frame_tick:
  - Equals frame_clk synchronised through 2 flops, ANDed with NOT the delayed copy.
  - One Clk-cycle pulse per frame.
- Fire acceptance:
  - Condition: rising edge of fire (fire & ~fire_prev) AND enable AND cooldown_cnt==0 AND at least one free slot.
  - Action: allocate the lowest-index free slot; x = spawn_x + X_OFFSET, truncated to 10 bits; y = SPAWN_Y; active=1.
  - Pulse fire_ack; load cooldown_cnt = COOLDOWN.
  - Slot state is visible the next cycle.
- Fire with all slots active: pulse fire_drop; no slot change; cooldown not loaded.
- Fire edge during cooldown: ignored silently; no ack, no drop.
- Held fire: yields at most one shot per press.
- Cooldown: decrements by 1 on each frame_tick while nonzero; saturates at 0.
- Motion on frame_tick, for each active slot:
  - DIR_UP=1: if y < SPEED, deactivate; else y -= SPEED.
  - DIR_UP=0: if y + SPEED >= SCREEN_H, deactivate; else y += SPEED.
  - Width: 11-bit intermediate; no wrap-around permitted.
- Hit handling:
  - hit_valid with hit_idx < NUM_BULLETS clears that slot next cycle.
  - Hit to an inactive slot or an out-of-range index: ignored.
- Simultaneous events, priority per slot: enable low > hit > spawn > motion.
  - Spawn and frame_tick in the same cycle: the new bullet holds SPAWN_Y and does not move that tick.
  - Hit and frame_tick on the same slot: the slot clears.
  - Hit freeing a slot and fire in the same cycle: allocation sees the pre-hit mask; that slot is not reusable until next cycle.
- enable low:
  - All slots cleared next cycle; cooldown_cnt cleared.
  - fire edges are neither acked nor dropped.
- Reset_n asserted mid-operation: immediately returns all state to reset values (asynchronous).
- Pixel query (combinational, zero latency):
  - Slot i covers the pixel when active AND x <= DrawX < x+BW AND y <= DrawY < y+BH.
  - Compare in 11 bits.
  - bullet_on = OR of all slot covers; bullet_idx = lowest covering index, else 0.
- active_mask and active_count: registered, consistent with slot state in the same cycle.

Decomposition:
- Package bullet_pkg:
  - typedef bullet_t {logic active; logic [9:0] x; logic [9:0] y;}
  - constants SCREEN_W=640 and SCREEN_H=480.
  - function first_free(mask) returning index plus valid.
- Sub-module bullet_slot:
  - One per slot; holds bullet_t.
  - Applies clear / spawn / move priority.
  - Outputs its own pixel cover.
- bullet_pool top: generate-loop of bullet_slot, plus allocator, cooldown counter, edge detectors and output reduction.

Test Plan:
- Reset, then fire edge with spawn_x=100 → fire_ack pulses; slot0 x=112, y=440; active_count=1; after 3 frame_ticks y=428.
- 4 fire edges with COOLDOWN=0 → slots 0-3 active; 5th edge → fire_drop=1, mask unchanged 4'b1111.
- COOLDOWN=8: fire, then fire edge 3 frames later → ignored; edge after 8 frame_ticks → accepted into slot1.
- Bullet at y=2, DIR_UP=1, frame_tick → slot deactivated, not wrapped; DIR_UP=0 instance with y=478 likewise deactivated.
- hit_valid with hit_idx=1 in the same cycle as frame_tick → slot1 cleared; other slots moved by SPEED; next fire edge allocates slot1.
- Slot0 at (200,300); DrawX=201, DrawY=307 → bullet_on=1, bullet_idx=0; DrawY=308 → bullet_on=0; enable low → mask=0 next cycle.
